snoop_bus_arbiter: RTL

Round-robin arbiter and transaction sequencer for the shared snooping coherence bus between NCPU per-line MESI cache controllers and main memory. It grants the bus to one requesting cache at a time and broadcasts that cache's bus message (read miss / write miss / invalidate) to all other caches. It collects snooper write-back requests and then sequences the memory access: fetch, write-back plus abort, or none.

---
 rtl/snoop_bus_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer for a shared snooping MESI bus.
// Define ARB_TIMEOUT_EN to abandon memory accesses that go TIMEOUT cycles without mem_ack.
module snoop_bus_arbiter #(
  parameter int unsigned NCPU      = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned SNOOP_CYC = 2,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                   Reset,
  input  logic                   clock,
  input  logic [NCPU-1:0]        req,
  input  logic [2*NCPU-1:0]      req_msg,
  input  logic [NCPU*ADDR_W-1:0] req_addr,
  output logic [NCPU-1:0]        gnt,
  output logic [1:0]             bus_msg,
  output logic [ADDR_W-1:0]      bus_addr,
  output logic [1:0]             bus_src,
  output logic [NCPU-1:0]        snoop_valid,
  input  logic [NCPU-1:0]        wb_req,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  output logic                   mem_abort,
  output logic [NCPU-1:0]        done,
  output logic                   err
);

  localparam logic [1:0] MsgNone   = 2'b00;
  localparam logic [1:0] MsgInv    = 2'b11;
  localparam logic [2:0] SnoopLast = 3'(SNOOP_CYC - 1);
  localparam logic [7:0] TmoLast   = 8'(TIMEOUT - 1);
  localparam logic [1:0] LastIdx   = 2'(NCPU - 1);
`ifdef ARB_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StBcast,
    StSnoop,
    StWb,
    StMem,
    StDone
  } state_e;

  state_e          state;
  logic [1:0]      ptr;
  logic            wb_flag;
  logic            abort_flag;
  logic            err_flag;
  logic [2:0]      snoop_cnt;
  logic [7:0]      tmo_cnt;

  logic [NCPU-1:0]   elig;
  logic [2*NCPU-1:0] elig_dbl;
  logic              any_elig;
  logic [1:0]        win;
  logic [NCPU-1:0]   win_oh;
  logic              wb_hit;
  logic [1:0]        ptr_next;

  // A cache whose done pulse is showing may not have dropped req yet, so it is
  // held out of arbitration for that one cycle to avoid a stale re-grant.
  always_comb begin
    for (int i = 0; i < NCPU; i++) begin
      elig[i] = req[i] && (req_msg[2*i +: 2] != MsgNone) && !done[i];
    end
  end

  always_comb begin
    elig_dbl = {elig, elig} >> ptr;
    any_elig = 1'b0;
    win      = ptr;
    for (int j = 0; j < NCPU; j++) begin
      if (!any_elig && elig_dbl[j]) begin
        any_elig = 1'b1;
        win      = 2'((int'(ptr) + j) % NCPU);
      end
    end
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  assign wb_hit   = |(wb_req & ~gnt);
  assign ptr_next = (bus_src == LastIdx) ? 2'b00 : bus_src + 2'b01;
  assign mem_addr = bus_addr;

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state       <= StIdle;
      ptr         <= '0;
      wb_flag     <= 1'b0;
      abort_flag  <= 1'b0;
      err_flag    <= 1'b0;
      snoop_cnt   <= '0;
      tmo_cnt     <= '0;
      gnt         <= '0;
      bus_msg     <= MsgNone;
      bus_addr    <= '0;
      bus_src     <= '0;
      snoop_valid <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_abort   <= 1'b0;
      done        <= '0;
      err         <= 1'b0;
    end else begin
      snoop_valid <= '0;
      mem_abort   <= 1'b0;
      done        <= '0;
      err         <= 1'b0;
      unique case (state)
        StIdle: begin
          if (any_elig) begin
            gnt         <= win_oh;
            bus_msg     <= req_msg[2*int'(win) +: 2];
            bus_addr    <= req_addr[int'(win)*ADDR_W +: ADDR_W];
            bus_src     <= win;
            snoop_valid <= ~win_oh;
            wb_flag     <= 1'b0;
            abort_flag  <= 1'b0;
            err_flag    <= 1'b0;
            state       <= StBcast;
          end
        end
        StBcast: begin
          snoop_cnt <= '0;
          state     <= StSnoop;
        end
        StSnoop: begin
          wb_flag <= wb_flag | wb_hit;
          if (snoop_cnt == SnoopLast) begin
            tmo_cnt <= '0;
            if (bus_msg == MsgInv) begin
              state <= StDone;
            end else if (wb_flag || wb_hit) begin
              mem_we <= 1'b1;
              state  <= StWb;
            end else begin
              mem_we <= 1'b0;
              state  <= StMem;
            end
          end else begin
            snoop_cnt <= snoop_cnt + 3'd1;
          end
        end
        StWb, StMem: begin
          // First cycle only presents the address; the request rises after it.
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else if (mem_ack) begin
            mem_req    <= 1'b0;
            abort_flag <= (state == StWb);
            state      <= StDone;
          end else if (TmoEn && (tmo_cnt == TmoLast)) begin
            mem_req  <= 1'b0;
            err_flag <= 1'b1;
            state    <= StDone;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        StDone: begin
          done      <= gnt;
          mem_abort <= abort_flag;
          err       <= err_flag;
          gnt       <= '0;
          bus_msg   <= MsgNone;
          mem_we    <= 1'b0;
          ptr       <= ptr_next;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
